gpu_memwriter: RTL
==================

GPU_MEMWRITER -- requirements
Module: gpu_memwriter

Interface
REQ-001 SHALL have parameter CHANNEL_BITS, default 8, bits per colour channel.
REQ-002 SHALL have parameter NUM_CHANNELS, default 3, channels per pixel.
REQ-003 SHALL have parameter WIDTH_BITS, default 10, and HEIGHT_BITS, default 9, giving coordinate widths.
REQ-004 SHALL have parameter SCREEN_WIDTH, default 640, giving pixels per row.
REQ-005 SHALL have parameter BUFFER_OFFSET, default 307200, giving the back-buffer base word address.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), giving pixel queue depth.
REQ-007 SHALL have parameter WRITE_CYCLES, default 2 (>=1), giving the write-strobe low time.
REQ-008 Ports (ADDR_BITS = WIDTH_BITS+HEIGHT_BITS+1; PIX_BITS = NUM_CHANNELS*CHANNEL_BITS):
  clk  in  1  system clock, rising edge
  rst  in  1  asynchronous, active-high reset
  pix_valid_i  in  1  pixel offered
  pix_ready_o  out  1  pixel accepted when valid&&ready
  pix_data_i  in  PIX_BITS  packed channels, channel 0 in MSBs
  pix_x_i  in  WIDTH_BITS  column
  pix_y_i  in  HEIGHT_BITS  row
  flush_i  in  1  frame-done pulse, requests buffer swap
  flush_done_o  out  1  one-cycle pulse on swap
  drop_o  out  1  one-cycle pulse, out-of-range pixel discarded
  sram_addr_o  out  ADDR_BITS  SRAM word address
  sram_data_o  out  PIX_BITS  SRAM write data
  sram_ce_n_o  out  1  chip enable, active low
  sram_we_n_o  out  1  write enable, active low
  sram_oe_n_o  out  1  output enable, active low
  buffer_select_o  out  1  current write buffer
  busy_o  out  1  FIFO non-empty or FSM not IDLE

Function
REQ-009 pix_ready_o SHALL equal !fifo_full && !flush_pending.
REQ-010 On accept, pixels with pix_x_i>=SCREEN_WIDTH SHALL be discarded with drop_o pulsed next cycle; others SHALL enqueue {pix_y_i*SCREEN_WIDTH+pix_x_i, pix_data_i}.
REQ-011 Address arithmetic SHALL be unsigned, ADDR_BITS wide, no saturation; issue address = queued address + (buffer_select ? BUFFER_OFFSET : 0).
REQ-012 FSM states: IDLE, SETUP, STROBE, HOLD.
REQ-013 IDLE->SETUP when FIFO non-empty; SETUP pops FIFO, registers addr/data, ce_n=0, we_n=1.
REQ-014 SETUP->STROBE; STROBE holds we_n=0, ce_n=0 for exactly WRITE_CYCLES cycles, addr/data stable.
REQ-015 STROBE->HOLD; HOLD: we_n=1, ce_n=0, addr/data stable; HOLD->SETUP if FIFO non-empty else IDLE.
REQ-016 IDLE: ce_n=1, we_n=1; sram_oe_n_o SHALL be 1 always.
REQ-017 Latency: pixel accepted at edge N into empty idle block SHALL be in SETUP in cycle N+1, we_n low cycles N+2..N+1+WRITE_CYCLES; throughput one pixel per WRITE_CYCLES+2 cycles.
REQ-018 flush_i SHALL set flush_pending; flush_i while pending SHALL be ignored.
REQ-019 When flush_pending && FIFO empty && IDLE, buffer_select SHALL toggle, flush_pending clear, flush_done_o pulse, all on one edge.
REQ-020 flush_i and an accepted pixel in the same cycle: pixel SHALL be written to the old buffer before the swap.
REQ-021 Full FIFO with simultaneous pop and push SHALL accept no push (ready already low); empty FIFO push then pop next cycle legal.

Reset
REQ-022 rst SHALL asynchronously clear FIFO, flush_pending, FSM to IDLE, buffer_select_o=0, pix_ready_o=1 after release, flush_done_o=0, drop_o=0, busy_o=0, ce_n=1, we_n=1, oe_n=1, sram_addr_o=0, sram_data_o=0.
REQ-023 rst mid-STROBE SHALL raise we_n immediately; the write is lost.

Structure
REQ-024 FSM state enum and default parameter constants SHALL reside in the shared gpu package.
REQ-025 FIFO SHALL be sub-module gpu_pixfifo (parametrised width/depth, push/pop/full/empty).

Verification
REQ-026 Single pixel (x=5,y=2,data=0xFF8040), buf 0 -> one write, addr 1285, we_n low 2 cycles.
REQ-027 Flush then pixel (x=0,y=0) -> buffer_select_o=1, flush_done_o one pulse, write addr 307200.
REQ-028 Burst of 6 pixels, valid held -> ready low at 4 queued, all 6 written in order, 4-cycle spacing.
REQ-029 x=640 -> drop_o pulse, no SRAM write.
REQ-030 flush_i with 3 queued -> swap only after third HOLD; pixels in old buffer; ready low meanwhile.
REQ-031 rst asserted mid-STROBE -> we_n=1, ce_n=1 same cycle, FIFO empty, buffer_select_o=0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: default parameter values for the pixel writer and the
// SRAM write-cycle state enumeration used by gpu_memwriter.
package gpu_pkg;

  localparam int unsigned DefChannelBits = 8;
  localparam int unsigned DefNumChannels = 3;
  localparam int unsigned DefWidthBits   = 10;
  localparam int unsigned DefHeightBits  = 9;
  localparam int unsigned DefScreenWidth = 640;
  localparam int unsigned DefBufferOffset = 307200;
  localparam int unsigned DefFifoDepth   = 4;
  localparam int unsigned DefWriteCycles = 2;

  // SRAM write sequence: address setup, write strobe, hold.
  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } wr_state_e;

endpackage

// File: rtl/gpu_pixfifo.sv
// Small synchronous FIFO holding {address, pixel} entries for the SRAM writer.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the queue)
//   push_i/wdata_i  enqueue request and data (ignored when full)
//   pop_i           dequeue request (ignored when empty)
//   rdata_o         head entry, valid while !empty_o
//   full_o/empty_o  occupancy flags
module gpu_pixfifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/gpu_memwriter.sv
// Pixel-to-SRAM writer with double buffering.
// Accepts pixels (x, y, colour), linearises them into word addresses, queues them
// and writes each to an asynchronous SRAM with a setup / strobe / hold sequence.
// A flush request swaps the write buffer once every queued pixel has been written.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pix_valid_i/pix_ready_o   pixel handshake; pix_data_i, pix_x_i, pix_y_i payload
//   flush_i / flush_done_o    swap request / one-cycle pulse when the swap happens
//   drop_o                    one-cycle pulse when an out-of-range pixel is discarded
//   sram_*_o                  SRAM address, data and active-low controls
//   buffer_select_o           buffer currently being written
//   busy_o                    queue non-empty or write sequence in progress
module gpu_memwriter
  import gpu_pkg::*;
#(
  parameter int unsigned CHANNEL_BITS  = DefChannelBits,
  parameter int unsigned NUM_CHANNELS  = DefNumChannels,
  parameter int unsigned WIDTH_BITS    = DefWidthBits,
  parameter int unsigned HEIGHT_BITS   = DefHeightBits,
  parameter int unsigned SCREEN_WIDTH  = DefScreenWidth,
  parameter int unsigned BUFFER_OFFSET = DefBufferOffset,
  parameter int unsigned FIFO_DEPTH    = DefFifoDepth,
  parameter int unsigned WRITE_CYCLES  = DefWriteCycles
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 pix_valid_i,
  output logic                                 pix_ready_o,
  input  logic [NUM_CHANNELS*CHANNEL_BITS-1:0] pix_data_i,
  input  logic [WIDTH_BITS-1:0]                pix_x_i,
  input  logic [HEIGHT_BITS-1:0]               pix_y_i,
  input  logic                                 flush_i,
  output logic                                 flush_done_o,
  output logic                                 drop_o,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]      sram_addr_o,
  output logic [NUM_CHANNELS*CHANNEL_BITS-1:0] sram_data_o,
  output logic                                 sram_ce_n_o,
  output logic                                 sram_we_n_o,
  output logic                                 sram_oe_n_o,
  output logic                                 buffer_select_o,
  output logic                                 busy_o
);

  localparam int unsigned ADDR_BITS = WIDTH_BITS + HEIGHT_BITS + 1;
  localparam int unsigned PIX_BITS  = NUM_CHANNELS * CHANNEL_BITS;
  localparam int unsigned EntW      = ADDR_BITS + PIX_BITS;
  localparam int unsigned CntW      = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WRITE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = 1;

  wr_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic                 ce_n_q, we_n_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [PIX_BITS-1:0]  data_q;
  logic                 flush_pending_q, buf_sel_q, flush_done_q, drop_q;

  logic                 accept, in_range, swap;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ADDR_BITS-1:0] lin_addr, q_addr, buf_base;
  logic [PIX_BITS-1:0]  q_data;
  logic [EntW-1:0]      fifo_rdata;

  assign pix_ready_o = !fifo_full && !flush_pending_q;
  assign accept      = pix_valid_i && pix_ready_o;
  assign in_range    = 32'(pix_x_i) < SCREEN_WIDTH;
  assign fifo_push   = accept && in_range;
  // Wraps modulo 2^ADDR_BITS by construction.
  assign lin_addr    = ADDR_BITS'(pix_y_i) * ADDR_BITS'(SCREEN_WIDTH) + ADDR_BITS'(pix_x_i);

  // The head is popped on the edge that enters SETUP, from IDLE or back-to-back from HOLD.
  assign fifo_pop = !fifo_empty && ((state_q == StIdle) || (state_q == StHold));
  assign {q_addr, q_data} = fifo_rdata;
  assign buf_base = buf_sel_q ? ADDR_BITS'(BUFFER_OFFSET) : '0;

  // Swap only once the queue has drained and the last write has fully completed.
  assign swap = flush_pending_q && fifo_empty && (state_q == StIdle);

  gpu_pixfifo #(
    .WIDTH (EntW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i ({lin_addr, pix_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q <= StSetup;
            ce_n_q  <= 1'b0;
            we_n_q  <= 1'b1;
            addr_q  <= q_addr + buf_base;
            data_q  <= q_data;
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          we_n_q  <= 1'b0;
          cnt_q   <= '0;
        end
        StStrobe: begin
          if (cnt_q == CntLast) begin
            state_q <= StHold;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHold: begin
          if (!fifo_empty) begin
            state_q <= StSetup;
            addr_q  <= q_addr + buf_base;
            data_q  <= q_data;
          end else begin
            state_q <= StIdle;
            ce_n_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          ce_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pending_q <= 1'b0;
      buf_sel_q       <= 1'b0;
      flush_done_q    <= 1'b0;
      drop_q          <= 1'b0;
    end else begin
      flush_done_q <= swap;
      drop_q       <= accept && !in_range;
      if (swap) begin
        buf_sel_q       <= ~buf_sel_q;
        flush_pending_q <= 1'b0;
      end else if (flush_i) begin
        flush_pending_q <= 1'b1;
      end
    end
  end

  assign flush_done_o    = flush_done_q;
  assign drop_o          = drop_q;
  assign sram_addr_o     = addr_q;
  assign sram_data_o     = data_q;
  assign sram_ce_n_o     = ce_n_q;
  assign sram_we_n_o     = we_n_q;
  assign sram_oe_n_o     = 1'b1;
  assign buffer_select_o = buf_sel_q;
  assign busy_o          = !fifo_empty || (state_q != StIdle);

endmodule
